// File: rtl/axi4lite_data_ram.sv
// axi4lite_data_ram
//   AXI4-Lite responder in front of a word-organised 32-bit data RAM.
//   It serves the load/store unit on the data-side interconnect.
//   The read channel (AR/R) and the write channel (AW/W/B) are independent and
//   run concurrently. An optional number of wait cycles sits between address
//   acceptance and the response, so masters can be exercised against latency.
//
//   Parameters
//     DEPTH_WORDS  RAM size in 32-bit words (power of two, >= 2)
//     WAIT_CYCLES  extra cycles between address acceptance and response (0..15)
//     INIT_FILE    optional memory image name; contents are left undefined
//
//   Ports
//     clk, rst_n                      clock (rising edge), async active-low reset
//     ar_addr/ar_valid/ar_ready       read address channel
//     r_data/r_resp/r_valid/r_ready   read response channel
//     aw_addr/aw_valid/aw_ready       write address channel
//     w_data/w_strb/w_valid/w_ready   write data channel
//     b_resp/b_valid/b_ready          write response channel
//
//   Read FSM
//     state  | meaning
//     R_IDLE | ar_ready high, waiting for an address
//     R_WAIT | address captured, burning WAIT_CYCLES cycles
//     R_RESP | r_valid high, data held until r_ready
//
//   Write FSM
//     state  | meaning
//     W_IDLE | collecting AW and W in either order
//     W_WAIT | both captured, burning WAIT_CYCLES cycles
//     W_RESP | RAM committed, b_valid high until b_ready
module axi4lite_data_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ar_addr,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic [31:0] r_data,
  output logic [1:0]  r_resp,
  output logic        r_valid,
  input  logic        r_ready,
  input  logic [31:0] aw_addr,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic [1:0]  b_resp,
  output logic        b_valid,
  input  logic        b_ready
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_TC   = 4'(WAIT_CYCLES);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Anything at or above 4*DEPTH_WORDS bytes is outside the RAM.
  function automatic logic addr_oor(input logic [31:0] a);
    return (a >> (AW + 2)) != 32'd0;
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-offset bits never select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ar_addr[1:0], aw_addr[1:0]};

  // ---------------------------------------------------------------- read side
  r_state_t      r_state, r_state_next;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_oor;
  logic          ar_hs;
  logic [AW-1:0] rd_idx_eff;
  logic          rd_oor_eff;
  logic          rd_sample;

  assign ar_ready = (r_state == R_IDLE);
  assign r_valid  = (r_state == R_RESP);
  assign ar_hs    = ar_valid && ar_ready;

  // With no wait cycles the RAM is sampled on the AR handshake edge itself,
  // so the live address is used instead of the not-yet-captured copy.
  assign rd_idx_eff = (r_state == R_IDLE) ? ar_addr[AW+1:2] : r_idx;
  assign rd_oor_eff = (r_state == R_IDLE) ? addr_oor(ar_addr) : r_oor;
  assign rd_sample  = (r_state != R_RESP) && (r_state_next == R_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_valid) r_state_next = (WAIT_CYCLES == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == WAIT_LAST) r_state_next = R_RESP;
      R_RESP:  if (r_ready) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_idx  <= '0;
      r_oor  <= 1'b0;
      r_data <= 32'd0;
      r_resp <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_idx <= ar_addr[AW+1:2];
        r_oor <= addr_oor(ar_addr);
        r_cnt <= 4'd0;
      end else if (r_state == R_WAIT && r_cnt != WAIT_TC) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (rd_sample) begin
        r_data <= rd_oor_eff ? 32'd0 : mem[rd_idx_eff];
        r_resp <= rd_oor_eff ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // --------------------------------------------------------------- write side
  w_state_t      w_state, w_state_next;
  logic [3:0]    w_cnt;
  logic          aw_got, w_got;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic          aw_hs, w_hs, both_in;
  logic [AW-1:0] wr_idx_eff;
  logic          wr_oor_eff;
  logic [31:0]   wr_data_eff;
  logic [3:0]    wr_strb_eff;
  logic          wr_commit;

  assign aw_ready = (w_state == W_IDLE) && !aw_got;
  assign w_ready  = (w_state == W_IDLE) && !w_got;
  assign b_valid  = (w_state == W_RESP);
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;
  assign both_in  = (aw_got || aw_hs) && (w_got || w_hs);

  // A half that arrives on the completing edge has not been captured yet.
  assign wr_idx_eff  = aw_got ? w_idx : aw_addr[AW+1:2];
  assign wr_oor_eff  = aw_got ? w_oor : addr_oor(aw_addr);
  assign wr_data_eff = w_got ? w_data_q : w_data;
  assign wr_strb_eff = w_got ? w_strb_q : w_strb;

  // Gated by rst_n so nothing commits while the FSM is held in reset.
  assign wr_commit = rst_n && (w_state != W_RESP) && (w_state_next == W_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      W_IDLE:  if (both_in) w_state_next = (WAIT_CYCLES == 0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt == WAIT_LAST) w_state_next = W_RESP;
      W_RESP:  if (b_ready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt    <= 4'd0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      w_idx    <= '0;
      w_oor    <= 1'b0;
      w_data_q <= 32'd0;
      w_strb_q <= 4'd0;
      b_resp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1;
        w_idx  <= aw_addr[AW+1:2];
        w_oor  <= addr_oor(aw_addr);
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (w_state == W_IDLE && both_in) begin
        w_cnt <= 4'd0;
      end else if (w_state == W_WAIT && w_cnt != WAIT_TC) begin
        w_cnt <= w_cnt + 4'd1;
      end
      // Captured halves stay flagged through W_WAIT so the muxes keep
      // pointing at the stored copies; they clear only on the B handshake.
      if (w_state == W_RESP && b_ready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (wr_commit) begin
        b_resp <= wr_oor_eff ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // RAM write port; the read above samples with the pre-edge contents, so a
  // same-edge read and commit to one word returns the old data.
  always_ff @(posedge clk) begin
    if (wr_commit && !wr_oor_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb_eff[i]) mem[wr_idx_eff][8*i +: 8] <= wr_data_eff[8*i +: 8];
      end
    end
  end

endmodule
